// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX-stage serial-divide interface.
// Produces {remainder, quotient} one quotient bit per cycle, with abort and divide-by-zero handling.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic                 dsign_q, dsign_d;
  logic                 qsign_q, qsign_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     diff;
  logic                 borrow;
  logic                 neg1, neg2;

  // Conditional two's-complement negation, used both for operand magnitudes and sign fix-up.
  function automatic logic [WIDTH-1:0] neg_cond(input logic signed [WIDTH-1:0] v,
                                                input logic                     en);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return en ? n : v;
  endfunction

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, div_q};
  // rem_sh < 2*divisor, so the top two difference bits are both set exactly when the trial borrows.
  assign borrow = &diff[WIDTH+1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    dsign_d  = dsign_q;
    qsign_d  = qsign_q;
    result_d = result_q;
    ready_d  = ready_q;
    neg1     = signed_div_i & opdata1_i[WIDTH-1];
    neg2     = signed_div_i & opdata2_i[WIDTH-1];

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = neg_cond(opdata1_i, neg1);
            div_d   = neg_cond(opdata2_i, neg2);
            dsign_d = neg1;
            qsign_d = neg1 ^ neg2;
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b1;
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != LAST_CNT) begin
          rem_d = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = S_END;
          result_d = {neg_cond(rem_q, dsign_q), neg_cond(quo_q, qsign_q)};
          ready_d  = 1'b1;
        end
      end

      S_END: begin
        ready_d = 1'b1;
        if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      dsign_q  <= 1'b0;
      qsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      dsign_q  <= dsign_d;
      qsign_q  <= qsign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors, randomized divides against a
// plain-arithmetic reference, abort, asynchronous reset and END-state hold behaviour.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Reference: integer division on 64-bit values (truncating, remainder sign follows dividend).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
    return (b == 32'd0) ? 1 : 33;
  endfunction

  // Start a divide and count edges from the sampling edge (0) until ready_o is observed.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit scramble, output logic [63:0] res, output int lat);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    lat          = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
        break;
      end
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
      end
    end
    res = result_o;
  endtask

  task automatic drop_start(output logic rdy, output logic [63:0] r);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rdy = ready_o;
    r   = result_o;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b want 0", ready_o);
    end
    checks++;
    if (result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_result: got %h want 0", result_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9,
                            32'h12345678, 32'h80000000, 32'h80000000};
    logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd2,
                            32'd0, 32'd0, 32'hFFFFFFFF};
    logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] te [7] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                            64'h00000001_FFFFFFFD, 64'h00000001_7FFFFFFC,
                            64'h0, 64'h0, 64'h00000000_80000000};
    int          tl [7] = '{33, 33, 33, 33, 1, 1, 33};
    logic [63:0] res, r2;
    logic        rdy;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_div(ta[i], tb[i], ts[i], 1'b0, res, lat);
      checks++;
      if (lat != tl[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
      end
      checks++;
      if (res !== te[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, res, te[i]);
      end
      drop_start(rdy, r2);
      checks++;
      if (rdy !== 1'b0 || r2 !== 64'd0) begin
        errors++;
        $display("FAIL directed_drop[%0d]: got ready=%0b result=%h want 0/0", i, rdy, r2);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    logic [63:0] res, exp, r2;
    logic        rdy;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 4 == 1) ? ($urandom & 32'h0000_00FF) : $urandom;
      s = 1'($urandom);
      if (i % 8 == 3) b = 32'd0;
      if (i % 10 == 7) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      exp = ref_div(a, b, s);
      run_div(a, b, s, 1'b0, res, lat);
      checks++;
      if (res !== exp || lat != ref_lat(b)) begin
        errors++;
        $display("FAIL random[%0d] %h/%h s=%0b: got %h lat %0d want %h lat %0d",
                 i, a, b, s, res, lat, exp, ref_lat(b));
      end
      drop_start(rdy, r2);
    end
  endtask

  task automatic test_annul;
    logic [63:0] res, r2;
    logic        rdy;
    int          lat;
    bit          seen;
    seen = 0;
    @(negedge clk);
    opdata1_i    = 32'd5000;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL annul_edge: got ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    annul_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul_no_ready: got ready seen=1 want 0");
    end
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== 64'h00000000_FFFFFFFF || lat != 33) begin
      errors++;
      $display("FAIL annul_restart: got %h lat %0d want 00000000ffffffff lat 33", res, lat);
    end
    drop_start(rdy, r2);
  endtask

  task automatic test_async_reset;
    logic [63:0] res, r2;
    logic        rdy;
    int          lat;
    @(negedge clk);
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd7;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_mid: got ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== 64'h00000000_00000003 || lat != 33) begin
      errors++;
      $display("FAIL async_reset_after: got %h lat %0d want 0000000000000003 lat 33", res, lat);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_end: got ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drop_start(rdy, r2);
  endtask

  task automatic test_scramble;
    logic [31:0] a, b;
    logic        s;
    logic [63:0] res, exp, r2;
    logic        rdy;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 2) ? 32'd0 : ($urandom >> (i * 4));
      if (b == 32'd0 && i != 2) b = 32'd1;
      s = 1'(i);
      exp = ref_div(a, b, s);
      run_div(a, b, s, 1'b1, res, lat);
      checks++;
      if (res !== exp || lat != ref_lat(b)) begin
        errors++;
        $display("FAIL scramble[%0d] %h/%h s=%0b: got %h lat %0d want %h lat %0d",
                 i, a, b, s, res, lat, exp, ref_lat(b));
      end
      drop_start(rdy, r2);
    end
  endtask

  task automatic test_hold_end;
    logic [63:0] res, exp, r2;
    logic        rdy;
    int          lat;
    bit          bad;
    bad = 0;
    exp = ref_div(32'd1000, 32'd33, 1'b0);
    run_div(32'd1000, 32'd33, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL hold_result: got %h want %h", res, exp);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (ready_o !== 1'b1 || result_o !== exp) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: got ready=%0b result=%h want 1/%h", ready_o, result_o, exp);
    end
    drop_start(rdy, r2);
    checks++;
    if (rdy !== 1'b0 || r2 !== 64'd0) begin
      errors++;
      $display("FAIL hold_drop: got ready=%0b result=%h want 0/0", rdy, r2);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r2;
    logic        rdy;
    int          lat;
    @(negedge clk);
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    lat     = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 33 || result_o !== 64'h00000000_0000000A) begin
      errors++;
      $display("FAIL start_annul_free: got %h lat %0d want 000000000000000a lat 33", result_o, lat);
    end
    drop_start(rdy, r2);
  endtask

  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (2) @(posedge clk);
    test_reset;
    test_directed;
    test_random;
    test_annul;
    test_async_reset;
    test_scramble;
    test_hold_end;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider sequencer serving the EX stage's serial-divide interface.
- Accepts start, operands and signedness from EX, iterates one quotient bit per cycle, and returns {remainder, quotient} with a ready flag.
- EX holds the pipeline stalled until ready rises, then deasserts start.
- Supports abort (annul) from EX on flush.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request/hold a divide; EX keeps high until it sees ready_o
annul_i  input  1  abort current divide
result_o  output  2*WIDTH  [2W-1:W] remainder (to HI), [W-1:0] quotient (to LO)
ready_o  output  1  result_o valid

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor regs=0. Reset mid-divide discards all work.
- States: FREE, BYZERO, ON, END. All outputs registered.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i=0 -> BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> ON. Latch operands; if signed_div_i and operand MSB=1, latch its two's-complement magnitude. Latch signedness, sign of dividend, and sign of quotient (MSB1^MSB2, signed only). Clear cnt; load partial remainder with 0 and shift reg with dividend magnitude.
  - Otherwise stay FREE; ready_o=0, result_o=0.
- BYZERO: next edge -> END, result_o=0, ready_o=1.
- ON:
  - annul_i=1 -> FREE next edge, ready_o=0, result_o=0, cnt=0. Annul has priority over iteration and completion.
  - Else if cnt!=WIDTH: one restoring step per edge. Shift {rem,dividend} left 1; trial = rem_hi - divisor (WIDTH+1-bit subtract). If no borrow, rem_hi=trial and quotient bit=1, else quotient bit=0. cnt++.
  - Else (cnt==WIDTH) -> END. Apply sign fix: quotient negated if quotient-sign=1; remainder negated if signed and dividend negative. Register result_o, set ready_o=1.
- Latency from start-sampling edge E0 (nonzero divisor): iterations at E1..E32, END at E33. ready_o first high after E33. Divide-by-zero: ready_o high after E1.
- Operands and signed_div_i changes after E0 are ignored.
- END:
  - ready_o=1, result_o held stable.
  - start_i=0 -> FREE next edge, ready_o=0, result_o=0.
  - start_i=1 -> stay END; a new divide needs start_i low for at least one cycle.
  - annul_i ignored in END.
- Arithmetic rules:
  - Signed -2^31 / -1 gives quotient 0x80000000 (wraps), remainder 0.
  - Remainder sign follows dividend; |remainder| < |divisor|.
  - Unsigned results must match exact integer division.
- Simultaneous start_i=1 & annul_i=1 in FREE: remain FREE.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises exactly 33 edges after start sampled; result_o=0x00000002_0000000E; drop start -> next edge ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9, 2) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9/2 -> 0x00000001_7FFFFFFC.
- Divisor 0 (any dividend, either signedness) -> ready_o high after 2nd edge, result_o=0. Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
- Annul asserted 10 cycles into ON -> FREE next edge, ready_o never rises. Immediate new start 0xFFFFFFFF/1 unsigned -> 0x00000000_FFFFFFFF after 33 edges.
- rst pulsed low asynchronously (between edges) mid-iteration -> ready_o=0, result_o=0 immediately. After release, start 9/3 -> 0x00000000_00000003.
- Operand inputs changed every cycle after E0 -> result reflects E0 values only. Start held in END -> no restart, result_o stable until start drops.
